param_seq_shifter: RTL and testbench

Parametrised multi-cycle universal shifter, the successor to the fixed 8-bit sequential shifter. It adds configurable data width, a configurable number of bits shifted per cycle, a rotate-left mode, a busy flag and a carry-out of the last bit shifted. It sits beside the ALU as a shared shift unit and uses the same start/done handshake, so existing sequencers drive it unchanged.

---
 rtl/param_seq_shifter.sv | 147 ++++++++++++++
 tb/tb_param_seq_shifter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_shifter.sv
// Multi-cycle universal shifter: LSL/LSR/ASR/ROR/ROL on a WIDTH-bit operand,
// up to STEP bits per cycle, with start/done handshake, busy flag and carry-out.
module param_seq_shifter #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ctrl,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    MODE_LSL = 3'd0,
    MODE_LSR = 3'd1,
    MODE_ASR = 3'd2,
    MODE_ROR = 3'd3,
    MODE_ROL = 3'd4
  } mode_e;

  localparam logic [AMT_W:0]   WIDTH_X = (AMT_W+1)'(WIDTH);
  localparam logic [AMT_W-1:0] STEP_X  = AMT_W'(STEP);

  state_e           state_q;
  mode_e            mode_q;
  logic [WIDTH-1:0] work_q;
  logic [AMT_W-1:0] remaining_q;
  logic             carry_q;

  logic [AMT_W-1:0] step_n;
  logic [AMT_W:0]   rot_n;
  logic [AMT_W-1:0] left_idx;
  logic [AMT_W-1:0] right_idx;
  logic [WIDTH-1:0] next_work;
  logic             next_carry;

  logic reserved;
  assign reserved = (ctrl > 3'd4);

  // One step of the datapath: shift by min(STEP, remaining). The carry tracks
  // the last bit leaving the word, which for rotates is also the bit that
  // lands in the result MSB (ROR) or LSB (ROL).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    next_work  = work_q;
    next_carry = carry_q;
    step_n     = (remaining_q < STEP_X) ? remaining_q : STEP_X;
    rot_n      = WIDTH_X - {1'b0, step_n};
    left_idx   = rot_n[AMT_W-1:0];
    right_idx  = step_n - AMT_W'(1);
    case (mode_q)
      MODE_LSL: begin
        next_work  = work_q << step_n;
        next_carry = work_q[left_idx];
      end
      MODE_LSR: begin
        next_work  = work_q >> step_n;
        next_carry = work_q[right_idx];
      end
      MODE_ASR: begin
        next_work  = $unsigned($signed(work_q) >>> step_n);
        next_carry = work_q[right_idx];
      end
      MODE_ROR: begin
        next_work  = (work_q >> step_n) | (work_q << rot_n);
        next_carry = work_q[right_idx];
      end
      MODE_ROL: begin
        next_work  = (work_q << step_n) | (work_q >> rot_n);
        next_carry = work_q[left_idx];
      end
      default: begin
        next_work  = work_q;
        next_carry = carry_q;
      end
    endcase
  end

  // Zero-distance and reserved requests enter SHIFT with nothing left to do,
  // so every request pays the same single capture cycle before DONE.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_LSL;
      work_q      <= '0;
      remaining_q <= '0;
      carry_q     <= 1'b0;
      data_out    <= '0;
      carry_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work_q      <= data_in;
            mode_q      <= reserved ? MODE_LSL : mode_e'(ctrl);
            remaining_q <= reserved ? '0 : shift_amt;
            carry_q     <= 1'b0;
            busy        <= 1'b1;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (remaining_q == '0) begin
            data_out  <= work_q;
            carry_out <= carry_q;
            done      <= 1'b1;
            state_q   <= DONE;
          end else begin
            work_q      <= next_work;
            carry_q     <= next_carry;
            remaining_q <= remaining_q - step_n;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_shifter.sv
// Self-checking bench: three WIDTH=8 instances (STEP 1/2/4) share one stimulus
// stream, one WIDTH=16/STEP=4 instance has its own; a scoreboard checks results.
module tb_param_seq_shifter;

  typedef struct {
    int          dut;
    logic [15:0] data;
    logic        carry;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8;
  logic [2:0]  ctrl8;
  logic [2:0]  amt8;
  logic [7:0]  din8;
  logic [7:0]  dout8 [3];
  logic        start16;
  logic [2:0]  ctrl16;
  logic [3:0]  amt16;
  logic [15:0] din16;
  logic [15:0] dout16;
  logic        carry_v [4];
  logic        busy_v  [4];
  logic        done_v  [4];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_w8
    param_seq_shifter #(.WIDTH(8), .STEP(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start8),
      .ctrl      (ctrl8),
      .shift_amt (amt8),
      .data_in   (din8),
      .data_out  (dout8[g]),
      .carry_out (carry_v[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g])
    );
  end

  param_seq_shifter #(.WIDTH(16), .STEP(4)) u_w16 (
    .clk       (clk),
    .rst       (rst),
    .start     (start16),
    .ctrl      (ctrl16),
    .shift_amt (amt16),
    .data_in   (din16),
    .data_out  (dout16),
    .carry_out (carry_v[3]),
    .busy      (busy_v[3]),
    .done      (done_v[3])
  );

  // Bit-at-a-time reference model.
  function automatic void model(input int w, input logic [2:0] c, input int amt,
                                input logic [15:0] d, output logic [15:0] r,
                                output logic cy);
    logic [15:0] mask;
    logic [15:0] msb;
    mask = 16'((32'h1 << w) - 1);
    r  = d & mask;
    cy = 1'b0;
    if (c > 3'd4) return;
    for (int i = 0; i < amt; i++) begin
      case (c)
        3'd0: begin cy = r[w-1]; r = (r << 1) & mask; end
        3'd1: begin cy = r[0];   r = r >> 1; end
        3'd2: begin cy = r[0]; msb = 16'(r[w-1]) << (w-1); r = (r >> 1) | msb; end
        3'd3: begin cy = r[0]; msb = 16'(cy) << (w-1); r = (r >> 1) | msb; end
        default: begin cy = r[w-1]; r = ((r << 1) & mask) | 16'(cy); end
      endcase
    end
  endfunction

  function automatic int latency(input logic [2:0] c, input int amt, input int step);
    if (c > 3'd4) return 0;
    return (amt + step - 1) / step;
  endfunction

  function automatic int pending(input int lo, input int hi);
    int n;
    n = 0;
    foreach (sb[j]) if (sb[j].dut >= lo && sb[j].dut <= hi) n++;
    return n;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation
  // for that instance, including the cycle it arrives on.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_v[i] === 1'b1) begin
        int          idx;
        logic [15:0] act;
        idx = -1;
        foreach (sb[j]) if (idx < 0 && sb[j].dut == i) idx = j;
        if (i == 3) act = dout16;
        else        act = {8'h00, dout8[i]};
        if (idx < 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done dut=%0d cycle=%0d got done=1 want 0", i, cyc);
        end else begin
          tests++;
          if (act !== sb[idx].data) begin
            fails++;
            $display("FAIL data_out dut=%0d got %h want %h", i, act, sb[idx].data);
          end
          tests++;
          if (carry_v[i] !== sb[idx].carry) begin
            fails++;
            $display("FAIL carry_out dut=%0d got %b want %b", i, carry_v[i], sb[idx].carry);
          end
          tests++;
          if (cyc != sb[idx].cyc) begin
            fails++;
            $display("FAIL done_cycle dut=%0d got %0d want %0d", i, cyc, sb[idx].cyc);
          end
          sb.delete(idx);
        end
      end
    end
  end

  task automatic wait_pending(input int lo, input int hi, input string name);
    for (int t = 0; t < 64 && pending(lo, hi) > 0; t++) begin
      @(negedge clk);
      #1;
    end
    tests++;
    if (pending(lo, hi) != 0) begin
      fails++;
      $display("FAIL %s timeout got %0d outstanding want 0", name, pending(lo, hi));
      for (int j = sb.size() - 1; j >= 0; j--)
        if (sb[j].dut >= lo && sb[j].dut <= hi) sb.delete(j);
    end
  endtask

  task automatic run8(input logic [2:0] c, input int amt, input logic [7:0] d,
                      input logic [7:0] ed, input logic ec, input string name);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (busy_v[i] !== 1'b0) begin
        fails++;
        $display("FAIL %s busy_idle dut=%0d got %b want 0", name, i, busy_v[i]);
      end
      sb.push_back('{i, {8'h00, ed}, ec, cyc + latency(c, amt, 1 << i) + 2});
    end
    ctrl8 = c; amt8 = 3'(amt); din8 = d; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; ctrl8 = 3'($urandom); amt8 = 3'($urandom); din8 = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (busy_v[i] !== 1'b1) begin
        fails++;
        $display("FAIL %s busy_after_start dut=%0d got %b want 1", name, i, busy_v[i]);
      end
    end
    wait_pending(0, 2, name);
  endtask

  task automatic run16(input logic [2:0] c, input int amt, input logic [15:0] d,
                       input logic [15:0] ed, input logic ec, input string name);
    @(negedge clk);
    tests++;
    if (busy_v[3] !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_idle dut=3 got %b want 0", name, busy_v[3]);
    end
    sb.push_back('{3, ed, ec, cyc + latency(c, amt, 4) + 2});
    ctrl16 = c; amt16 = 4'(amt); din16 = d; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; ctrl16 = 3'($urandom); amt16 = 4'($urandom); din16 = 16'($urandom);
    wait_pending(3, 3, name);
  endtask

  task automatic check_idle8(input string name);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (dout8[i] !== 8'h00 || carry_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
        fails++;
        $display("FAIL %s dut=%0d got out=%h c=%b busy=%b done=%b want 00 0 0 0",
                 name, i, dout8[i], carry_v[i], busy_v[i], done_v[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; ctrl8 = '0; amt8 = '0; din8 = '0;
    start16 = 1'b0; ctrl16 = '0; amt16 = '0; din16 = '0;
    repeat (3) @(negedge clk);
    check_idle8("reset");
    tests++;
    if (dout16 !== 16'h0 || carry_v[3] !== 1'b0 || busy_v[3] !== 1'b0 || done_v[3] !== 1'b0) begin
      fails++;
      $display("FAIL reset dut=3 got out=%h c=%b busy=%b done=%b want 0000 0 0 0",
               dout16, carry_v[3], busy_v[3], done_v[3]);
    end
    rst = 1'b0;
  endtask

  task automatic test_modes8();
    run8(3'd0, 1, 8'hB3, 8'h66, 1'b1, "lsl1");
    run8(3'd1, 2, 8'hB3, 8'h2C, 1'b1, "lsr2");
    run8(3'd2, 3, 8'hB3, 8'hF6, 1'b0, "asr3");
    run8(3'd3, 4, 8'hB3, 8'h3B, 1'b0, "ror4");
    run8(3'd4, 3, 8'hB3, 8'h9D, 1'b1, "rol3");
  endtask

  task automatic test_zero_reserved();
    run8(3'd0, 0, 8'hA5, 8'hA5, 1'b0, "amt0");
    run8(3'd6, 5, 8'h3C, 8'h3C, 1'b0, "reserved");
  endtask

  task automatic test_w16();
    run16(3'd2, 15, 16'h8001, 16'hFFFF, 1'b0, "w16_asr15");
    run16(3'd4, 9,  16'h00F1, 16'hE201, 1'b1, "w16_rol9");
  endtask

  task automatic test_busy_start();
    logic [15:0] r;
    logic        cy;
    model(8, 3'd0, 7, 16'h004D, r, cy);
    @(negedge clk);
    for (int i = 0; i < 3; i++) sb.push_back('{i, r, cy, cyc + latency(3'd0, 7, 1 << i) + 2});
    ctrl8 = 3'd0; amt8 = 3'd7; din8 = 8'h4D; start8 = 1'b1;
    // Start stays high through the STEP=4 instance's DONE cycle.
    repeat (4) begin
      @(negedge clk);
      ctrl8 = 3'($urandom); amt8 = 3'($urandom); din8 = 8'($urandom);
      tests++;
      if (busy_v[0] !== 1'b1) begin
        fails++;
        $display("FAIL busy_start busy dut=0 got %b want 1", busy_v[0]);
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    wait_pending(0, 2, "busy_start");
    repeat (12) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    logic        cy;
    model(16, 3'd3, 5, 16'h1234, r, cy);
    run16(3'd3, 5, 16'h1234, r, cy, "b2b_first");
    model(16, 3'd1, 1, 16'hBEEF, r, cy);
    run16(3'd1, 1, 16'hBEEF, r, cy, "b2b_second");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ctrl8 = 3'd0; amt8 = 3'd6; din8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle8("reset_mid");
    repeat (12) @(negedge clk);
    run8(3'd0, 1, 8'h01, 8'h02, 1'b0, "after_reset");
  endtask

  task automatic test_rst_start();
    @(negedge clk);
    rst = 1'b1; ctrl8 = 3'd1; amt8 = 3'd3; din8 = 8'hF0; start8 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    check_idle8("rst_start");
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] r;
    logic        cy;
    logic [7:0]  d;
    logic [15:0] d16;
    for (int c = 0; c < 8; c++) begin
      for (int a = 0; a < 8; a++) begin
        d = 8'($urandom);
        model(8, 3'(c), a, {8'h00, d}, r, cy);
        run8(3'(c), a, d, r[7:0], cy, "random8");
      end
    end
    for (int n = 0; n < 24; n++) begin
      logic [2:0] c16;
      int         a16;
      c16 = 3'($urandom_range(0, 5));
      a16 = $urandom_range(0, 15);
      d16 = 16'($urandom);
      model(16, c16, a16, d16, r, cy);
      run16(c16, a16, d16, r, cy, "random16");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_modes8();
    test_zero_reserved();
    test_w16();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_rst_start();
    test_random();
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
